bin_to_bcd_seq: RTL and testbench

Sequential binary-to-BCD converter using iterative shift-and-add-3 (double dabble). It takes an unsigned binary value, converts it over a fixed number of clock cycles and presents a packed multi-digit BCD result. Each 4-bit digit drives one BCD-to-seven-segment decoder downstream. A start/done handshake lets a counter or measurement block request a conversion whenever its value changes.

---
 rtl/bin_to_bcd_seq_if.sv | 48 ++++
 rtl/bin_to_bcd_seq.sv | 140 ++++++++++++++
 tb/tb_bin_to_bcd_seq.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/bin_to_bcd_seq_if.sv
// ---------------------------------------------------------------------------
// bin_to_bcd_seq_if
// Start/done handshake bundle between a requester (counter, measurement
// block) and the bin_to_bcd_seq converter.
//
// Parameters:
//   BIN_W  - width of the unsigned binary value
//   DIGITS - number of BCD digits in the result
// Signals:
//   start    - conversion request (requester -> converter)
//   bin_in   - value to convert, captured with an accepted start
//   busy     - conversion in progress (converter -> requester)
//   done     - one-cycle pulse, result valid
//   bcd_out  - packed BCD result, digit 0 in [3:0]
//   overflow - last value did not fit in DIGITS digits
// Modports:
//   master - requester side
//   slave  - converter side
// ---------------------------------------------------------------------------
interface bin_to_bcd_seq_if #(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
);
    logic                  start;
    logic [BIN_W-1:0]      bin_in;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd_out;
    logic                  overflow;

    modport master (
        output start,
        output bin_in,
        input  busy,
        input  done,
        input  bcd_out,
        input  overflow
    );

    modport slave (
        input  start,
        input  bin_in,
        output busy,
        output done,
        output bcd_out,
        output overflow
    );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// ---------------------------------------------------------------------------
// bin_to_bcd_seq
// Sequential binary-to-BCD converter (shift-and-add-3 / double dabble).
// One bit of the binary value is shifted into the BCD digits per clock, so
// a conversion takes BIN_W cycles after the accepting edge.
//
// Parameters:
//   BIN_W  - binary input width (>= 4)
//   DIGITS - number of BCD digits produced
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - bin_to_bcd_seq_if.slave handshake (start, bin_in, busy, done,
//           bcd_out, overflow)
// Build option:
//   BCD_LEADING_ZERO_BLANK_EN - when defined, leading zero digits above
//   digit 0 are replaced with 4'hF so a downstream 7-segment decoder
//   turns them off.
// ---------------------------------------------------------------------------
module bin_to_bcd_seq #(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    bin_to_bcd_seq_if.slave     bus
);

    localparam int BCD_W  = 4 * DIGITS;
    localparam int WORK_W = BCD_W + BIN_W;
    localparam int CNT_W  = $clog2(BIN_W + 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    // Largest value representable in DIGITS decimal digits: 10^DIGITS - 1.
    function automatic logic [63:0] max_value();
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < DIGITS; i++) begin
            p = p * 64'd10;
        end
        return p - 64'd1;
    endfunction

    localparam logic [63:0] MAX_VAL = max_value();

    logic [0:0]        state;
    logic [WORK_W-1:0] work;
    logic [CNT_W-1:0]  cnt;
    logic              pending_ovf;
    logic [BCD_W-1:0]  bcd_reg;
    logic              ovf_reg;
    logic              done_reg;

    logic [WORK_W-1:0] work_adj;
    logic [WORK_W-1:0] work_next;
    logic [BCD_W-1:0]  result_digits;
    logic [BCD_W-1:0]  result_final;
    logic              in_overflow;

    // Overflow is decided on the captured binary value rather than on the
    // BCD field, because digits shifted past the top are simply lost.
    assign in_overflow = (64'(bus.bin_in) > MAX_VAL);

    // Add-3 correction on every BCD digit >= 5, then shift left by one.
    // The binary part sits below the digits and has no correction.
    always_comb begin
        work_adj = work;
        for (int d = 0; d < DIGITS; d++) begin
            if (work[BIN_W + 4*d +: 4] >= 4'd5) begin
                work_adj[BIN_W + 4*d +: 4] = work[BIN_W + 4*d +: 4] + 4'd3;
            end
        end
        work_next = {work_adj[WORK_W-2:0], 1'b0};
    end

    // Result as it will be registered on the final shift, including
    // saturation and optional leading-zero blanking.
    always_comb begin
        result_digits = work_next[WORK_W-1 -: BCD_W];
`ifdef BCD_LEADING_ZERO_BLANK_EN
        begin
            logic still_leading;
            still_leading = 1'b1;
            for (int d = DIGITS - 1; d > 0; d--) begin
                if (still_leading && (result_digits[4*d +: 4] == 4'd0)) begin
                    result_digits[4*d +: 4] = 4'hF;
                end else begin
                    still_leading = 1'b0;
                end
            end
        end
`endif
        result_final = pending_ovf ? {DIGITS{4'h9}} : result_digits;
    end

    // Control FSM and datapath registers. The result registers are only
    // written on the final shift, so intermediate values never appear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            work        <= '0;
            cnt         <= '0;
            pending_ovf <= 1'b0;
            bcd_reg     <= '0;
            ovf_reg     <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        work        <= {{BCD_W{1'b0}}, bus.bin_in};
                        cnt         <= CNT_W'(BIN_W);
                        pending_ovf <= in_overflow;
                        state       <= SHIFT;
                    end
                end
                SHIFT: begin
                    work <= work_next;
                    cnt  <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        bcd_reg  <= result_final;
                        ovf_reg  <= pending_ovf;
                        done_reg <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy     = (state == SHIFT);
    assign bus.done     = done_reg;
    assign bus.bcd_out  = bcd_reg;
    assign bus.overflow = ovf_reg;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// ---------------------------------------------------------------------------
// tb_bin_to_bcd_seq
// Directed, table-driven bench for bin_to_bcd_seq at default parameters
// (BIN_W=14, DIGITS=4), plus hand-written multi-cycle sequences for
// ignored start, back-to-back start, mid-conversion reset and input changes
// after acceptance. Honours BCD_LEADING_ZERO_BLANK_EN in its expectations.
// ---------------------------------------------------------------------------
module tb_bin_to_bcd_seq;

    localparam int BIN_W   = 14;
    localparam int DIGITS  = 4;
    localparam int LATENCY = 14;

    logic clk;
    logic rst_n;
    int   cycle_count;
    int   accept_cycle;
    int   check_count;
    int   error_count;

    bin_to_bcd_seq_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) bus ();

    bin_to_bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle_count <= cycle_count + 1;

    typedef struct {
        logic [13:0] bin;
        logic [15:0] bcd;
        logic        ovf;
    } vec_t;

    vec_t vecs[8];

    // Expected display value: plain BCD, or blanked leading zeros when the
    // build option is on (saturated overflow results are never blanked).
    function automatic logic [15:0] expBcd(input logic [15:0] v, input logic ovf);
        logic [15:0] r;
        r = v;
`ifdef BCD_LEADING_ZERO_BLANK_EN
        if (!ovf) begin
            for (int d = 3; d > 0; d--) begin
                if (r[d*4 +: 4] == 4'd0) r[d*4 +: 4] = 4'hF;
                else break;
            end
        end
`else
        if (ovf) r = v;
`endif
        return r;
    endfunction

    task automatic checkValue(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic checkOutput(input string name, input logic [15:0] bcd,
                               input logic ovf);
        checkValue({name, "_bcd"}, 32'(bus.bcd_out), 32'(expBcd(bcd, ovf)));
        checkValue({name, "_ovf"}, 32'(bus.overflow), 32'(ovf));
    endtask

    // Present a request for one cycle; returns #1 after the accepting edge.
    task automatic applyStimulus(input logic [13:0] value);
        bus.start  = 1'b1;
        bus.bin_in = value;
        @(posedge clk);
        #1;
        accept_cycle = cycle_count;
        bus.start = 1'b0;
    endtask

    // Wait (bounded) for done; checks the accept-to-done latency.
    task automatic waitDone(input string name);
        int n;
        n = 0;
        while (!bus.done && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkValue({name, "_done_seen"}, 32'(bus.done), 32'd1);
        checkValue({name, "_latency"}, 32'(cycle_count - accept_cycle), 32'(LATENCY));
        checkValue({name, "_busy_at_done"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        check_count  = 0;
        error_count  = 0;
        cycle_count  = 0;
        accept_cycle = 0;
        rst_n      = 1'b0;
        bus.start  = 1'b0;
        bus.bin_in = '0;

        vecs[0] = '{bin: 14'd0,     bcd: 16'h0000, ovf: 1'b0};
        vecs[1] = '{bin: 14'd1234,  bcd: 16'h1234, ovf: 1'b0};
        vecs[2] = '{bin: 14'd42,    bcd: 16'h0042, ovf: 1'b0};
        vecs[3] = '{bin: 14'd9999,  bcd: 16'h9999, ovf: 1'b0};
        vecs[4] = '{bin: 14'd10000, bcd: 16'h9999, ovf: 1'b1};
        vecs[5] = '{bin: 14'd16383, bcd: 16'h9999, ovf: 1'b1};
        vecs[6] = '{bin: 14'd100,   bcd: 16'h0100, ovf: 1'b0};
        vecs[7] = '{bin: 14'd8765,  bcd: 16'h8765, ovf: 1'b0};

        repeat (3) @(posedge clk);
        #1;
        checkValue("reset_busy", 32'(bus.busy), 32'd0);
        checkValue("reset_done", 32'(bus.done), 32'd0);
        checkValue("reset_bcd", 32'(bus.bcd_out), 32'd0);
        checkValue("reset_ovf", 32'(bus.overflow), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] table vectors");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].bin);
            checkValue($sformatf("vec%0d_busy", i), 32'(bus.busy), 32'd1);
            waitDone($sformatf("vec%0d", i));
            checkOutput($sformatf("vec%0d", i), vecs[i].bcd, vecs[i].ovf);
            @(posedge clk);
            #1;
            checkValue($sformatf("vec%0d_done_width", i), 32'(bus.done), 32'd0);
            checkOutput($sformatf("vec%0d_hold", i), vecs[i].bcd, vecs[i].ovf);
        end

        $display("[TB] start while busy is ignored, then back-to-back");
        applyStimulus(14'd5678);
        repeat (4) @(posedge clk);
        #1;
        bus.start  = 1'b1;
        bus.bin_in = 14'd1111;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        checkValue("ignored_no_early_done", 32'(bus.done), 32'd0);
        waitDone("ignored");
        checkOutput("ignored", 16'h5678, 1'b0);
        bus.start  = 1'b1;
        bus.bin_in = 14'd321;
        @(posedge clk);
        #1;
        accept_cycle = cycle_count;
        bus.start = 1'b0;
        checkValue("b2b_busy", 32'(bus.busy), 32'd1);
        checkValue("b2b_done_low", 32'(bus.done), 32'd0);
        waitDone("b2b");
        checkOutput("b2b", 16'h0321, 1'b0);
        @(posedge clk);
        #1;

        $display("[TB] reset mid-conversion");
        applyStimulus(14'd9999);
        repeat (6) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkValue("abort_busy", 32'(bus.busy), 32'd0);
        checkValue("abort_done", 32'(bus.done), 32'd0);
        checkValue("abort_bcd", 32'(bus.bcd_out), 32'd0);
        checkValue("abort_ovf", 32'(bus.overflow), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(14'd7);
        waitDone("after_abort");
        checkOutput("after_abort", 16'h0007, 1'b0);
        @(posedge clk);
        #1;

        $display("[TB] bin_in change after acceptance");
        applyStimulus(14'd500);
        repeat (3) @(posedge clk);
        #1;
        bus.bin_in = 14'd800;
        waitDone("hold_in");
        checkOutput("hold_in", 16'h0500, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
